// File: rtl/ram_march_tester.sv
// rtl/ram_march_tester.sv - four-pass march self-test initiator for a single-port synchronous RAM
// Optional: RAM_MARCH_TESTER_CHECKERBOARD_EN selects a per-address checkerboard background.
module ram_march_tester #(
  parameter int                    ADDRESS_WIDTH = 16,
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    MEMORY_DEPTH  = 2**ADDRESS_WIDTH,
  parameter logic [DATA_WIDTH-1:0] PATTERN       = '0
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Start_i,
  output logic                     Busy_o,
  output logic                     Done_o,
  output logic                     Pass_o,
  output logic                     Fail_o,
  output logic [ADDRESS_WIDTH-1:0] FailAddress_o,
  output logic [DATA_WIDTH-1:0]    FailData_o,
  output logic                     RamReadEnable_o,
  output logic                     RamWriteEnable_o,
  output logic [ADDRESS_WIDTH-1:0] RamAddress_o,
  output logic [DATA_WIDTH-1:0]    RamData_o,
  input  logic [DATA_WIDTH-1:0]    RamData_i
);

  typedef enum logic [2:0] {S_IDLE, S_P0, S_P1, S_P2, S_P3, S_FLUSH, S_DONE} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);

  if (MEMORY_DEPTH < 2 || MEMORY_DEPTH > 2**ADDRESS_WIDTH) begin : g_depth_check
    $fatal(1, "ram_march_tester: MEMORY_DEPTH out of range");
  end

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d, done_q, done_d, pass_q, pass_d, fail_q, fail_d;
  logic [ADDRESS_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0]    fail_data_q, fail_data_d;
  logic                    re_q, re_d, we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d, exp_q, exp_d;
  logic                    pipe_valid_q;
  logic [DATA_WIDTH-1:0]    pipe_exp_q;
  logic [ADDRESS_WIDTH-1:0] pipe_addr_q;
  logic [DATA_WIDTH-1:0]    bg;
  logic                    compare_active, mismatch;

  // The pipeline holds the read the RAM sampled last edge; its data is on RamData_i now.
  assign compare_active = (state_q == S_P0) || (state_q == S_P1) || (state_q == S_P2) ||
                          (state_q == S_P3) || (state_q == S_FLUSH);
  assign mismatch = compare_active && pipe_valid_q && (RamData_i != pipe_exp_q);

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    re_d        = 1'b0;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    exp_d       = exp_q;

    case (state_q)
      S_IDLE: if (Start_i) begin
        state_d     = S_P0;
        addr_d      = '0;
        busy_d      = 1'b1;
        pass_d      = 1'b0;
        fail_d      = 1'b0;
        fail_addr_d = '0;
        fail_data_d = '0;
      end
      S_P0: if (addr_q == LAST_ADDRESS) begin
        state_d = S_P1;
        addr_d  = '0;
      end else addr_d = addr_q + ADDRESS_WIDTH'(1);
      S_P1: if (addr_q == LAST_ADDRESS) begin
        state_d = S_P2;
        addr_d  = LAST_ADDRESS;
      end else addr_d = addr_q + ADDRESS_WIDTH'(1);
      S_P2: if (addr_q == '0) begin
        state_d = S_P3;
        addr_d  = LAST_ADDRESS;
      end else addr_d = addr_q - ADDRESS_WIDTH'(1);
      S_P3: if (addr_q == '0) state_d = S_FLUSH;
            else addr_d = addr_q - ADDRESS_WIDTH'(1);
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (mismatch && !fail_q) begin
      state_d     = S_DONE;
      addr_d      = addr_q;
      fail_d      = 1'b1;
      fail_addr_d = pipe_addr_q;
      fail_data_d = RamData_i;
    end

`ifdef RAM_MARCH_TESTER_CHECKERBOARD_EN
    bg = addr_d[0] ? ~PATTERN : PATTERN;
`else
    bg = PATTERN;
`endif

    // Strobes and data belong to the command being registered for the next cycle.
    case (state_d)
      S_P0: begin we_d = 1'b1; data_d = bg; end
      S_P1: begin re_d = 1'b1; we_d = 1'b1; data_d = ~bg; exp_d = bg; end
      S_P2: begin re_d = 1'b1; we_d = 1'b1; data_d = bg; exp_d = ~bg; end
      S_P3: begin re_d = 1'b1; exp_d = bg; end
      S_DONE: begin done_d = 1'b1; busy_d = 1'b0; pass_d = ~fail_d; end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      exp_q        <= '0;
      pipe_valid_q <= 1'b0;
      pipe_exp_q   <= '0;
      pipe_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      fail_addr_q  <= fail_addr_d;
      fail_data_q  <= fail_data_d;
      re_q         <= re_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      exp_q        <= exp_d;
      pipe_valid_q <= re_q;
      pipe_exp_q   <= exp_q;
      pipe_addr_q  <= addr_q;
    end
  end

  assign Busy_o           = busy_q;
  assign Done_o           = done_q;
  assign Pass_o           = pass_q;
  assign Fail_o           = fail_q;
  assign FailAddress_o    = fail_addr_q;
  assign FailData_o       = fail_data_q;
  assign RamReadEnable_o  = re_q;
  assign RamWriteEnable_o = we_q;
  assign RamAddress_o     = addr_q;
  assign RamData_o        = data_q;

endmodule
